mux_scan_sequencer: RTL and testbench

Upstream control stage for the 16-to-1 single-bit channel multiplexer. It drives the mux select lines through channels 0..15 and samples the single-bit mux output once per channel after a programmable settle time. It then assembles the 16 samples into a parallel word and presents that word with a one-cycle valid strobe. It supports one-shot and continuous scanning with a start/stop/busy handshake.

---
 rtl/mux_scan_sequencer_if.sv | 20 ++
 rtl/mux_scan_sequencer.sv | 110 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_if.sv
// Handshake and mux-facing signals of the 16-channel scan sequencer.
// master = controller/mux side, slave = sequencer side.
interface mux_scan_sequencer_if;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned DATA_W = 16;

  logic              start;
  logic              cont;
  logic              stop;
  logic              mux_out;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              busy;

  modport master (output start, cont, stop, mux_out,
                  input  sel, data, valid, busy);
  modport slave  (input  start, cont, stop, mux_out,
                  output sel, data, valid, busy);
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 16:1 mux through all channels, samples each after SETTLE extra
// cycles, and presents the assembled word with a one-cycle valid strobe.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_scan_sequencer_if.slave  bus
);

  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(15);
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]        state,  state_n;
  logic [SEL_W-1:0]  sel_q,  sel_n;
  logic [CNT_W-1:0]  cnt_q,  cnt_n;
  logic [DATA_W-1:0] shreg,  shreg_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              valid_q, valid_n;
  logic              busy_q,  busy_n;
  logic              cflag,   cflag_n;

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    cnt_n   = cnt_q;
    shreg_n = shreg;
    data_n  = data_q;
    valid_n = 1'b0;
    busy_n  = busy_q;
    cflag_n = cflag;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        sel_n  = '0;
        if (bus.start) begin
          state_n = SCAN;
          cnt_n   = RELOAD;
          shreg_n = '0;
          cflag_n = bus.cont & ~bus.stop;
          busy_n  = 1'b1;
        end
      end
      SCAN: begin
        if (bus.stop) cflag_n = 1'b0;
        if (cnt_q == '0) begin
          shreg_n = {bus.mux_out, shreg[DATA_W-1:1]};
          cnt_n   = RELOAD;
          if (sel_q != LAST_CH) begin
            sel_n = SEL_W'(sel_q + SEL_W'(1));
          end else begin
            // End of scan: publish the whole word at once
            data_n  = {bus.mux_out, shreg[DATA_W-1:1]};
            valid_n = 1'b1;
            sel_n   = '0;
            if (!(cflag & ~bus.stop)) begin
              state_n = IDLE;
              cnt_n   = '0;
              busy_n  = 1'b0;
            end
          end
        end else begin
          cnt_n = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cflag   <= 1'b0;
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      cnt_q   <= cnt_n;
      shreg   <= shreg_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      cflag   <= cflag_n;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: SETTLE=1 instance for one-shot,
// continuous, stop, ignored-start and reset cases; SETTLE=0 instance for timing.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_scan_sequencer_if a ();
  mux_scan_sequencer_if b ();

  logic [15:0] pat_a = 16'h0000;
  logic [15:0] pat_b = 16'h0000;

  // Combinational models of the downstream muxes
  assign a.mux_out = pat_a[a.sel];
  assign b.mux_out = pat_b[b.sel];

  mux_scan_sequencer #(.SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  mux_scan_sequencer #(.SETTLE(0)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  typedef struct {
    logic [15:0] pat;
    logic        inj_start;
    logic [15:0] exp_data;
  } vec_t;

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One-shot scan on the SETTLE=1 instance; i counts negedges after E0
  task automatic oneshot(input vec_t v);
    pat_a = v.pat;
    @(negedge clk);
    a.start = 1'b1;
    a.cont  = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      a.start = 1'b0;
      a.cont  = 1'b0;
      if (v.inj_start && i == 11) begin
        a.start = 1'b1;
        a.cont  = 1'b1;
      end
      if (i <= 32) begin
        check("os_sel", 16'(a.sel), 16'((i - 1) / 2));
        check("os_valid_low", 16'(a.valid), 16'(0));
        check("os_busy_high", 16'(a.busy), 16'(1));
      end else if (i == 33) begin
        check("os_valid", 16'(a.valid), 16'(1));
        check("os_data", a.data, v.exp_data);
        check("os_busy_fall", 16'(a.busy), 16'(0));
        check("os_sel_idle", 16'(a.sel), 16'(0));
      end else begin
        check("os_no_extra_valid", 16'(a.valid), 16'(0));
        check("os_idle_busy", 16'(a.busy), 16'(0));
      end
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{pat: 16'hA5C3, inj_start: 1'b0, exp_data: 16'hA5C3};
    vecs[1] = '{pat: 16'h0000, inj_start: 1'b0, exp_data: 16'h0000};
    vecs[2] = '{pat: 16'hFFFF, inj_start: 1'b0, exp_data: 16'hFFFF};
    vecs[3] = '{pat: 16'h6C39, inj_start: 1'b1, exp_data: 16'h6C39};
    vecs[4] = '{pat: 16'h0001, inj_start: 1'b0, exp_data: 16'h0001};

    a.start = 1'b0; a.cont = 1'b0; a.stop = 1'b0;
    b.start = 1'b0; b.cont = 1'b0; b.stop = 1'b0;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_sel", 16'(a.sel), 16'(0));
    check("rst_data", a.data, 16'h0000);
    check("rst_valid", 16'(a.valid), 16'(0));
    check("rst_busy", 16'(a.busy), 16'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // stop in IDLE has no effect
    a.stop = 1'b1;
    @(negedge clk);
    a.stop = 1'b0;
    check("idle_stop_busy", 16'(a.busy), 16'(0));

    for (int n = 0; n < 5; n++) oneshot(vecs[n]);

    // Continuous: 1234, then FFFE, then 8001 with stop at channel 9
    pat_a = 16'h1234;
    @(negedge clk);
    a.start = 1'b1;
    a.cont  = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      a.start = 1'b0;
      a.cont  = 1'b0;
      a.stop  = 1'b0;
      check("ct_valid", 16'(a.valid), 16'((i == 33 || i == 65 || i == 97) ? 1 : 0));
      check("ct_busy", 16'(a.busy), 16'((i < 97) ? 1 : 0));
      if (i == 33) begin
        check("ct_data0", a.data, 16'h1234);
        pat_a = 16'hFFFE;
      end
      if (i == 65) begin
        check("ct_data1", a.data, 16'hFFFE);
        pat_a = 16'h8001;
      end
      if (i == 83) begin
        check("ct_sel_ch9", 16'(a.sel), 16'(9));
        a.stop = 1'b1;
      end
      if (i == 97) check("ct_data2", a.data, 16'h8001);
      if (i >= 97) check("ct_sel_idle", 16'(a.sel), 16'(0));
    end

    // Asynchronous reset in channel 7 of a scan
    pat_a = 16'hBEEF;
    @(negedge clk);
    a.start = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      a.start = 1'b0;
    end
    check("ar_sel_ch7", 16'(a.sel), 16'(7));
    #2 rst = 1'b1;
    #1;
    check("ar_sel", 16'(a.sel), 16'(0));
    check("ar_data", a.data, 16'h0000);
    check("ar_valid", 16'(a.valid), 16'(0));
    check("ar_busy", 16'(a.busy), 16'(0));
    @(negedge clk);
    rst = 1'b0;
    oneshot('{pat: 16'hBEEF, inj_start: 1'b0, exp_data: 16'hBEEF});

    // SETTLE=0 instance: one channel per cycle
    pat_b = 16'h5A5A;
    @(negedge clk);
    b.start = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      b.start = 1'b0;
      if (i <= 16) begin
        check("s0_sel", 16'(b.sel), 16'(i - 1));
        check("s0_valid_low", 16'(b.valid), 16'(0));
        check("s0_busy", 16'(b.busy), 16'(1));
      end else if (i == 17) begin
        check("s0_valid", 16'(b.valid), 16'(1));
        check("s0_data", b.data, 16'h5A5A);
        check("s0_busy_fall", 16'(b.busy), 16'(0));
      end else begin
        check("s0_no_extra_valid", 16'(b.valid), 16'(0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
